// File: rtl/axi_burst_mem_responder.sv
// AXI4 slave that serves INCR bursts from an internal byte-enabled memory.
// Write and read paths are independent, one outstanding burst per direction.
module axi_burst_mem_responder #(
  parameter int unsigned AXI_ID_WIDTH   = 1,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_AW         = 12
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic                      S_AWVALID,
  output logic                      S_AWREADY,
  input  logic [AXI_ID_WIDTH-1:0]   S_AWID,
  input  logic [AXI_ADDR_WIDTH-1:0] S_AWADDR,
  input  logic [7:0]                S_AWLEN,
  input  logic [2:0]                S_AWSIZE,
  input  logic [1:0]                S_AWBURST,
  input  logic                      S_WVALID,
  output logic                      S_WREADY,
  input  logic [DATA_WIDTH-1:0]     S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]   S_WSTRB,
  input  logic                      S_WLAST,
  output logic                      S_BVALID,
  input  logic                      S_BREADY,
  output logic [AXI_ID_WIDTH-1:0]   S_BID,
  output logic [1:0]                S_BRESP,
  input  logic                      S_ARVALID,
  output logic                      S_ARREADY,
  input  logic [AXI_ID_WIDTH-1:0]   S_ARID,
  input  logic [AXI_ADDR_WIDTH-1:0] S_ARADDR,
  input  logic [7:0]                S_ARLEN,
  input  logic [2:0]                S_ARSIZE,
  input  logic [1:0]                S_ARBURST,
  output logic                      S_RVALID,
  input  logic                      S_RREADY,
  output logic [AXI_ID_WIDTH-1:0]   S_RID,
  output logic [DATA_WIDTH-1:0]     S_RDATA,
  output logic [1:0]                S_RRESP,
  output logic                      S_RLAST,
  output logic [31:0]               WR_BURSTS,
  output logic [31:0]               RD_BURSTS,
  output logic                      PROTO_ERR
);
  localparam int unsigned LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned HI  = MEM_AW + LSB;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic req_err(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                   input logic [2:0] size, input logic [1:0] burst);
    logic [AXI_ADDR_WIDTH-1:0] w_hi;
    w_hi = addr >> HI;
    return (burst != 2'b01) || (size != 3'(LSB)) || (w_hi != '0);
  endfunction

  logic [DATA_WIDTH-1:0] r_mem [2**MEM_AW];
  // Keeps the address READYs low while reset is held and for the release edge.
  logic r_en;

  // Write path
  w_state_e                r_wst, w_wst_d;
  logic [AXI_ID_WIDTH-1:0] r_wid;
  logic [MEM_AW-1:0]       r_widx;
  logic [7:0]              r_wcnt;
  logic                    r_werr, r_wmis, r_proto_err;
  logic [31:0]             r_wr_bursts;
  logic                    w_aw_hs, w_w_hs, w_b_hs, w_wmis;

  assign w_aw_hs = S_AWVALID && S_AWREADY;
  assign w_w_hs  = S_WVALID && S_WREADY;
  assign w_b_hs  = S_BVALID && S_BREADY;
  assign w_wmis  = (r_wcnt == 8'd0) != S_WLAST;

  always_comb begin
    w_wst_d   = r_wst;
    S_AWREADY = 1'b0;
    S_WREADY  = 1'b0;
    S_BVALID  = 1'b0;
    unique case (r_wst)
      W_IDLE: begin
        S_AWREADY = r_en;
        if (S_AWVALID && r_en) w_wst_d = W_DATA;
      end
      W_DATA: begin
        S_WREADY = 1'b1;
        if (S_WVALID && (r_wcnt == 8'd0)) w_wst_d = W_RESP;
      end
      W_RESP: begin
        S_BVALID = 1'b1;
        if (S_BREADY) w_wst_d = W_IDLE;
      end
      default: w_wst_d = W_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_en        <= 1'b0;
      r_wst       <= W_IDLE;
      r_wid       <= '0;
      r_widx      <= '0;
      r_wcnt      <= '0;
      r_werr      <= 1'b0;
      r_wmis      <= 1'b0;
      r_proto_err <= 1'b0;
      r_wr_bursts <= '0;
    end else begin
      r_en  <= 1'b1;
      r_wst <= w_wst_d;
      if (w_aw_hs) begin
        r_wid  <= S_AWID;
        r_widx <= S_AWADDR[HI-1:LSB];
        r_wcnt <= S_AWLEN;
        r_werr <= req_err(S_AWADDR, S_AWSIZE, S_AWBURST);
        r_wmis <= 1'b0;
      end
      if (w_w_hs) begin
        r_widx <= r_widx + MEM_AW'(1);
        r_wcnt <= r_wcnt - 8'd1;
        if (w_wmis) begin
          r_wmis      <= 1'b1;
          r_proto_err <= 1'b1;
        end
      end
      if (w_b_hs) r_wr_bursts <= r_wr_bursts + 32'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN && w_w_hs && !r_werr) begin
      for (int b = 0; b < NB; b++) begin
        if (S_WSTRB[b]) r_mem[r_widx][8*b +: 8] <= S_WDATA[8*b +: 8];
      end
    end
  end

  // Read path: issue stage -> memory register (M) -> output register (O).
  // M doubles as the skid slot when O is stalled by RREADY.
  r_state_e                r_rstate, w_rstate_d;
  logic [AXI_ID_WIDTH-1:0] r_rid;
  logic                    r_rerr, r_iss;
  logic [MEM_AW-1:0]       r_ridx;
  logic [7:0]              r_rcnt;
  logic                    r_m_vld, r_m_last, r_rvalid, r_rlast;
  logic [DATA_WIDTH-1:0]   r_m_data, r_rdata;
  logic [31:0]             r_rd_bursts;
  logic                    w_ar_hs, w_o_free, w_m_free, w_issue, w_r_done;

  assign w_ar_hs  = S_ARVALID && S_ARREADY;
  assign w_o_free = !r_rvalid || S_RREADY;
  assign w_m_free = !r_m_vld || w_o_free;
  assign w_issue  = r_iss && w_m_free;
  assign w_r_done = r_rvalid && S_RREADY && r_rlast;

  always_comb begin
    w_rstate_d = r_rstate;
    S_ARREADY  = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        S_ARREADY = r_en;
        if (S_ARVALID && r_en) w_rstate_d = R_DATA;
      end
      R_DATA: if (w_r_done) w_rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_rstate    <= R_IDLE;
      r_rid       <= '0;
      r_rerr      <= 1'b0;
      r_iss       <= 1'b0;
      r_ridx      <= '0;
      r_rcnt      <= '0;
      r_m_vld     <= 1'b0;
      r_m_last    <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
      r_rdata     <= '0;
      r_rd_bursts <= '0;
    end else begin
      r_rstate <= w_rstate_d;
      if (w_ar_hs) begin
        r_rid  <= S_ARID;
        r_ridx <= S_ARADDR[HI-1:LSB];
        r_rcnt <= S_ARLEN;
        r_rerr <= req_err(S_ARADDR, S_ARSIZE, S_ARBURST);
        r_iss  <= 1'b1;
      end
      if (w_issue) begin
        r_ridx <= r_ridx + MEM_AW'(1);
        r_rcnt <= r_rcnt - 8'd1;
        if (r_rcnt == 8'd0) r_iss <= 1'b0;
      end
      if (w_m_free) begin
        r_m_vld  <= w_issue;
        r_m_last <= (r_rcnt == 8'd0);
      end
      if (w_o_free) begin
        r_rvalid <= r_m_vld;
        r_rlast  <= r_m_vld && r_m_last;
        if (r_m_vld) r_rdata <= r_m_data;
      end
      if (w_r_done) r_rd_bursts <= r_rd_bursts + 32'd1;
    end
  end

  // Synchronous read, read-first against a same-cycle write.
  always_ff @(posedge CLK) begin
    if (w_issue) r_m_data <= r_rerr ? '0 : r_mem[r_ridx];
  end

  assign S_BID     = r_wid;
  assign S_BRESP   = (r_werr || r_wmis) ? 2'b10 : 2'b00;
  assign S_RVALID  = r_rvalid;
  assign S_RID     = r_rid;
  assign S_RDATA   = r_rdata;
  assign S_RRESP   = r_rerr ? 2'b10 : 2'b00;
  assign S_RLAST   = r_rlast;
  assign WR_BURSTS = r_wr_bursts;
  assign RD_BURSTS = r_rd_bursts;
  assign PROTO_ERR = r_proto_err;

endmodule

// File: tb/tb_axi_burst_mem_responder.sv
// Directed bench for axi_burst_mem_responder: bursts, wrap, error responses,
// RREADY back-pressure and mid-burst reset.
module tb_axi_burst_mem_responder;
  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic        S_AWVALID, S_AWREADY, S_WVALID, S_WREADY, S_WLAST, S_BVALID, S_BREADY;
  logic [0:0]  S_AWID, S_BID, S_ARID, S_RID;
  logic [31:0] S_AWADDR, S_ARADDR, S_WDATA, S_RDATA, WR_BURSTS, RD_BURSTS;
  logic [7:0]  S_AWLEN, S_ARLEN;
  logic [2:0]  S_AWSIZE, S_ARSIZE;
  logic [1:0]  S_AWBURST, S_ARBURST, S_BRESP, S_RRESP;
  logic [3:0]  S_WSTRB;
  logic        S_ARVALID, S_ARREADY, S_RVALID, S_RREADY, S_RLAST, PROTO_ERR;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_data [16];

  always #5 CLK = ~CLK;

  axi_burst_mem_responder #(
    .AXI_ID_WIDTH(1), .AXI_ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_AW(12)
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWID(S_AWID), .S_AWADDR(S_AWADDR),
    .S_AWLEN(S_AWLEN), .S_AWSIZE(S_AWSIZE), .S_AWBURST(S_AWBURST),
    .S_WVALID(S_WVALID), .S_WREADY(S_WREADY), .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB),
    .S_WLAST(S_WLAST),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY), .S_BID(S_BID), .S_BRESP(S_BRESP),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY), .S_ARID(S_ARID), .S_ARADDR(S_ARADDR),
    .S_ARLEN(S_ARLEN), .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY), .S_RID(S_RID), .S_RDATA(S_RDATA),
    .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .WR_BURSTS(WR_BURSTS), .RD_BURSTS(RD_BURSTS), .PROTO_ERR(PROTO_ERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wr_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                          input logic [31:0] base, input int last_at, output logic [1:0] resp);
    int n;
    S_AWID = 1'b1; S_AWADDR = addr; S_AWLEN = len; S_AWSIZE = 3'd2; S_AWBURST = burst;
    S_AWVALID = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!S_AWREADY && n < 50) begin n++; @(negedge CLK); end
    chk("awready", {31'd0, S_AWREADY}, 32'd1);
    @(posedge CLK); #1 S_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      S_WVALID = 1'b1;
      S_WDATA  = base + 32'(i);
      S_WSTRB  = 4'hF;
      S_WLAST  = (last_at < 0) ? (i == int'(len)) : (i == last_at);
      n = 0;
      @(negedge CLK);
      while (!S_WREADY && n < 50) begin n++; @(negedge CLK); end
      if (!S_WREADY) chk("wready_timeout", {31'd0, S_WREADY}, 32'd1);
      @(posedge CLK); #1;
    end
    S_WVALID = 1'b0; S_WLAST = 1'b0;
    S_BREADY = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!S_BVALID && n < 50) begin n++; @(negedge CLK); end
    chk("bvalid", {31'd0, S_BVALID}, 32'd1);
    chk("bid", {31'd0, S_BID}, 32'd1);
    resp = S_BRESP;
    @(posedge CLK); #1 S_BREADY = 1'b0;
  endtask

  task automatic rd_burst(input logic [31:0] addr, input logic [7:0] len, input bit toggle,
                          output int nbeats, output int first_c, output int last_c,
                          output logic [1:0] resp);
    int n, c;
    bit done, stall;
    logic [31:0] held;
    S_ARID = 1'b0; S_ARADDR = addr; S_ARLEN = len; S_ARSIZE = 3'd2; S_ARBURST = 2'b01;
    S_ARVALID = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!S_ARREADY && n < 50) begin n++; @(negedge CLK); end
    chk("arready", {31'd0, S_ARREADY}, 32'd1);
    @(posedge CLK); #1 S_ARVALID = 1'b0;
    c = 0; done = 0; stall = 0; held = '0;
    nbeats = 0; first_c = -1; last_c = -1; resp = 2'b00;
    while (!done && c < 200) begin
      S_RREADY = toggle ? (c[0] == 1'b0) : 1'b1;
      @(negedge CLK);
      if (stall) chk("rdata_hold", S_RDATA, held);
      stall = S_RVALID && !S_RREADY;
      held  = S_RDATA;
      if (S_RVALID && S_RREADY) begin
        if (first_c < 0) first_c = c;
        if (nbeats < 16) rd_data[nbeats] = S_RDATA;
        resp = resp | S_RRESP;
        nbeats++;
        if (S_RLAST) begin done = 1; last_c = c; end
      end
      @(posedge CLK); #1;
      c++;
    end
    S_RREADY = 1'b0;
    if (!done) chk("rlast_timeout", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    int nb, fc, lc;
    S_AWVALID = 0; S_AWID = 0; S_AWADDR = 0; S_AWLEN = 0; S_AWSIZE = 0; S_AWBURST = 0;
    S_WVALID = 0; S_WDATA = 0; S_WSTRB = 0; S_WLAST = 0; S_BREADY = 0;
    S_ARVALID = 0; S_ARID = 0; S_ARADDR = 0; S_ARLEN = 0; S_ARSIZE = 0; S_ARBURST = 0;
    S_RREADY = 0;

    // Reset state
    RSTN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_awready", {31'd0, S_AWREADY}, 32'd0);
    chk("rst_arready", {31'd0, S_ARREADY}, 32'd0);
    chk("rst_bvalid", {31'd0, S_BVALID}, 32'd0);
    chk("rst_rvalid", {31'd0, S_RVALID}, 32'd0);
    chk("rst_rdata", S_RDATA, 32'd0);
    chk("rst_wr_bursts", WR_BURSTS, 32'd0);
    chk("rst_rd_bursts", RD_BURSTS, 32'd0);
    chk("rst_proto_err", {31'd0, PROTO_ERR}, 32'd0);
    RSTN = 1'b1;
    @(posedge CLK); #1;
    chk("rel_awready", {31'd0, S_AWREADY}, 32'd1);
    chk("rel_arready", {31'd0, S_ARREADY}, 32'd1);

    // 16-beat write then readback at 0x40
    wr_burst(32'h40, 8'd15, 2'b01, 32'd1, -1, resp);
    chk("w16_bresp", {30'd0, resp}, 32'd0);
    chk("w16_wr_bursts", WR_BURSTS, 32'd1);
    rd_burst(32'h40, 8'd15, 1'b0, nb, fc, lc, resp);
    chk("r16_beats", nb, 32'd16);
    chk("r16_first", fc, 32'd2);
    chk("r16_last", lc, 32'd17);
    chk("r16_rresp", {30'd0, resp}, 32'd0);
    for (int i = 0; i < 16; i++) chk($sformatf("r16_data%0d", i), rd_data[i], 32'(i + 1));
    chk("r16_rd_bursts", RD_BURSTS, 32'd1);

    // 4 beats, RREADY high: first beat at t+2, consecutive
    rd_burst(32'h44, 8'd3, 1'b0, nb, fc, lc, resp);
    chk("r4_first", fc, 32'd2);
    chk("r4_last", lc, 32'd5);
    for (int i = 0; i < 4; i++) chk($sformatf("r4_data%0d", i), rd_data[i], 32'(i + 2));

    // 4 beats with RREADY toggling: data held across stalls
    rd_burst(32'h40, 8'd3, 1'b1, nb, fc, lc, resp);
    chk("r4t_beats", nb, 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("r4t_data%0d", i), rd_data[i], 32'(i + 1));
    chk("r4t_rd_bursts", RD_BURSTS, 32'd3);

    // Wrap: words 4094, 4095, 0, 1
    wr_burst(32'h3FF8, 8'd3, 2'b01, 32'h100, -1, resp);
    chk("wrap_bresp", {30'd0, resp}, 32'd0);
    rd_burst(32'h3FF8, 8'd3, 1'b0, nb, fc, lc, resp);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_data%0d", i), rd_data[i], 32'h100 + 32'(i));
    rd_burst(32'h0, 8'd0, 1'b0, nb, fc, lc, resp);
    chk("wrap_word0_beats", nb, 32'd1);
    chk("wrap_word0", rd_data[0], 32'h102);

    // FIXED burst: accepted, nothing written, SLVERR
    wr_burst(32'h40, 8'd3, 2'b00, 32'hAA, -1, resp);
    chk("fixed_bresp", {30'd0, resp}, 32'd2);
    chk("fixed_wr_bursts", WR_BURSTS, 32'd3);
    rd_burst(32'h40, 8'd3, 1'b0, nb, fc, lc, resp);
    for (int i = 0; i < 4; i++) chk($sformatf("fixed_mem%0d", i), rd_data[i], 32'(i + 1));
    chk("fixed_rresp", {30'd0, resp}, 32'd0);

    // Out-of-range read address
    rd_burst(32'h8000_0000, 8'd0, 1'b0, nb, fc, lc, resp);
    chk("oor_beats", nb, 32'd1);
    chk("oor_rresp", {30'd0, resp}, 32'd2);
    chk("oor_rdata", rd_data[0], 32'd0);
    chk("oor_rd_bursts", RD_BURSTS, 32'd7);
    chk("pre_mis_proto_err", {31'd0, PROTO_ERR}, 32'd0);

    // Early WLAST on beat 2 of 4
    wr_burst(32'h100, 8'd3, 2'b01, 32'h50, 1, resp);
    chk("mis_bresp", {30'd0, resp}, 32'd2);
    chk("mis_proto_err", {31'd0, PROTO_ERR}, 32'd1);
    wr_burst(32'h200, 8'd0, 2'b01, 32'h77, -1, resp);
    chk("post_mis_bresp", {30'd0, resp}, 32'd0);
    chk("sticky_proto_err", {31'd0, PROTO_ERR}, 32'd1);
    chk("mis_wr_bursts", WR_BURSTS, 32'd5);

    // Reset in the middle of an 8-beat read
    S_ARID = 1'b0; S_ARADDR = 32'h40; S_ARLEN = 8'd7; S_ARSIZE = 3'd2; S_ARBURST = 2'b01;
    S_ARVALID = 1'b1;
    @(negedge CLK);
    chk("mr_arready", {31'd0, S_ARREADY}, 32'd1);
    @(posedge CLK); #1 S_ARVALID = 1'b0;
    S_RREADY = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    chk("mr_rvalid_mid", {31'd0, S_RVALID}, 32'd1);
    RSTN = 1'b0;
    @(posedge CLK); #1;
    chk("mr_rvalid", {31'd0, S_RVALID}, 32'd0);
    chk("mr_arready_rst", {31'd0, S_ARREADY}, 32'd0);
    chk("mr_wr_bursts", WR_BURSTS, 32'd0);
    chk("mr_rd_bursts", RD_BURSTS, 32'd0);
    chk("mr_proto_err", {31'd0, PROTO_ERR}, 32'd0);
    S_RREADY = 1'b0;
    RSTN = 1'b1;
    @(posedge CLK); #1;
    chk("mr_arready_rel", {31'd0, S_ARREADY}, 32'd1);
    rd_burst(32'h40, 8'd0, 1'b0, nb, fc, lc, resp);
    chk("mr_mem_kept", rd_data[0], 32'd1);
    chk("mr_rd_after", RD_BURSTS, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
